// File: rtl/final_layer_pkg.sv
// Shared types and width helper for the serial BNN output layer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package final_layer_pkg;

    // Controller states of the serial output layer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to encode n distinct values, never less than one
    function automatic int fl_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational XNOR-popcount of one weight chunk against one activation chunk.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows inputs every cycle.
module xnor_popcount #(
    parameter  int WIDTH = 49,
    localparam int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [OUT_W-1:0] out
);

    // Matching bits count as +1 contributions to the neuron pre-activation
    always_comb begin
        out = OUT_W'($countones(a ~^ b));
    end

endmodule

// File: rtl/final_layer_serial.sv
// Serial BNN output layer: streams each class's weight row chunk by chunk, keeps running argmax.
// Latency: NUM_CLASSES*NUM_CHUNKS cycles from input acceptance to out_valid.
// Backpressure: in_ready low while busy; result held stable until out_ready. FINAL_LAYER_MARGIN_EN adds the margin output.
module final_layer_serial
    import final_layer_pkg::*;
#(
    parameter  int NUM_INPUTS  = 196,
    parameter  int NUM_CLASSES = 10,
    parameter  int CHUNK_WIDTH = 49,
    localparam int NUM_CHUNKS  = NUM_INPUTS / CHUNK_WIDTH,
    localparam int IDX_W       = fl_width(NUM_CLASSES),
    localparam int CHK_W       = fl_width(NUM_CHUNKS),
    localparam int CNT_W       = fl_width(NUM_INPUTS + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_INPUTS-1:0]  data_in,
    output logic [IDX_W-1:0]       w_class,
    output logic [CHK_W-1:0]       w_chunk,
    input  logic [CHUNK_WIDTH-1:0] w_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       answer,
    output logic [CNT_W-1:0]       score
`ifdef FINAL_LAYER_MARGIN_EN
    ,
    output logic [CNT_W-1:0]       margin
`else
    // margin port is not built in this configuration
`endif
);

    localparam int PC_W = $clog2(CHUNK_WIDTH + 1);

    // The feature vector must split into whole chunks
    if (NUM_INPUTS % CHUNK_WIDTH != 0) begin : g_bad_chunking
        $error("final_layer_serial: NUM_INPUTS must be a multiple of CHUNK_WIDTH");
    end

    state_t                               r_state;
    state_t                               w_next_state;
    logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]                     r_cls;
    logic [CHK_W-1:0]                     r_chunk;
    logic [CNT_W-1:0]                     r_acc;
    logic [CNT_W-1:0]                     r_best_score;
    logic [IDX_W-1:0]                     r_best_idx;
    logic [IDX_W-1:0]                     r_answer;
    logic [CNT_W-1:0]                     r_score;
    logic [PC_W-1:0]                      w_pc;
    logic [CNT_W-1:0]                     w_total;
    logic                                 w_last_chunk;
    logic                                 w_last_class;
    logic                                 w_take;
    logic [CNT_W-1:0]                     w_new_best_score;
    logic [IDX_W-1:0]                     w_new_best_idx;
`ifdef FINAL_LAYER_MARGIN_EN
    logic [CNT_W-1:0]                     r_second;
    logic [CNT_W-1:0]                     r_margin;
    logic [CNT_W-1:0]                     w_new_second;
`endif

    xnor_popcount #(
        .WIDTH (CHUNK_WIDTH)
    ) u_popcount (
        .a   (w_data),
        .b   (r_data[r_chunk]),
        .out (w_pc)
    );

    // State register; reset always returns to IDLE and drops any result
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept in IDLE, walk all class/chunk pairs, hold result until taken
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = ACCUM;
            ACCUM:   if (w_last_chunk && w_last_class) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs; both forced low while reset is asserted
    always_comb begin
        in_ready  = !reset && (r_state == IDLE);
        out_valid = !reset && (r_state == DONE);
    end

    // Chunk accumulation and argmax candidate for the class being finished
    always_comb begin
        w_last_chunk     = (r_chunk == CHK_W'(NUM_CHUNKS - 1));
        w_last_class     = (r_cls == IDX_W'(NUM_CLASSES - 1));
        w_total          = r_acc + CNT_W'(w_pc);
        // Strict greater-than keeps the lowest index on ties
        w_take           = (r_cls == '0) || (w_total > r_best_score);
        w_new_best_score = w_take ? w_total : r_best_score;
        w_new_best_idx   = w_take ? r_cls : r_best_idx;
`ifdef FINAL_LAYER_MARGIN_EN
        // A new leader demotes the old one; otherwise a strong loser can raise the runner-up
        w_new_second = r_second;
        if (w_take) begin
            w_new_second = r_best_score;
        end else if (w_total > r_second) begin
            w_new_second = w_total;
        end
`endif
    end

    // Feature vector capture; only loaded on acceptance so it is untouched while busy
    always_ff @(posedge clock) begin
        if (!reset && r_state == IDLE && in_valid) begin
            r_data <= data_in;
        end
    end

    // Counters, accumulator, argmax and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cls        <= '0;
            r_chunk      <= '0;
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
            r_answer     <= '0;
            r_score      <= '0;
`ifdef FINAL_LAYER_MARGIN_EN
            r_second     <= '0;
            r_margin     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cls        <= '0;
                        r_chunk      <= '0;
                        r_acc        <= '0;
                        r_best_score <= '0;
                        r_best_idx   <= '0;
`ifdef FINAL_LAYER_MARGIN_EN
                        r_second     <= '0;
`endif
                    end
                end
                ACCUM: begin
                    if (!w_last_chunk) begin
                        r_acc   <= w_total;
                        r_chunk <= r_chunk + 1'b1;
                    end else begin
                        r_best_score <= w_new_best_score;
                        r_best_idx   <= w_new_best_idx;
`ifdef FINAL_LAYER_MARGIN_EN
                        r_second     <= w_new_second;
`endif
                        r_acc        <= '0;
                        r_chunk      <= '0;
                        // Counters park at zero after the final class so ROM address reads 0
                        r_cls        <= w_last_class ? '0 : r_cls + 1'b1;
                        if (w_last_class) begin
                            r_answer <= w_new_best_idx;
                            r_score  <= w_new_best_score;
`ifdef FINAL_LAYER_MARGIN_EN
                            r_margin <= w_new_best_score - w_new_second;
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_class = r_cls;
    assign w_chunk = r_chunk;
    assign answer  = r_answer;
    assign score   = r_score;
`ifdef FINAL_LAYER_MARGIN_EN
    assign margin  = r_margin;
`endif

endmodule

// File: tb/tb_final_layer_serial.sv
// Self-checking bench for final_layer_serial: default instance plus a small-parameter instance.
// Latency: checks NUM_CLASSES*NUM_CHUNKS cycles to out_valid.
// Backpressure: exercises held results, ignored inputs and mid-operation reset.
module tb_final_layer_serial;

    localparam int N   = 196;
    localparam int NC  = 10;
    localparam int CW  = 49;
    localparam int NCH = 4;
    localparam int SN  = 64;
    localparam int SNC = 3;
    localparam int SCW = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0]  data_in;
    logic [3:0]    w_class, answer;
    logic [1:0]    w_chunk;
    logic [CW-1:0] w_data;
    logic [7:0]    score;
    logic [N-1:0]  rom [16];

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [SN-1:0] s_data_in;
    logic [1:0]    s_w_class, s_answer, s_w_chunk;
    logic [SCW-1:0] s_w_data;
    logic [6:0]    s_score;
    logic [SN-1:0] s_rom [4];
`ifdef FINAL_LAYER_MARGIN_EN
    logic [7:0]    margin;
    logic [6:0]    s_margin;
`endif

    int n_checks = 0;
    int n_errors = 0;

    final_layer_serial u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .w_class(w_class), .w_chunk(w_chunk), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .answer(answer), .score(score)
`ifdef FINAL_LAYER_MARGIN_EN
        , .margin(margin)
`endif
    );

    final_layer_serial #(.NUM_INPUTS(SN), .NUM_CLASSES(SNC), .CHUNK_WIDTH(SCW)) u_small (
        .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .data_in(s_data_in), .w_class(s_w_class), .w_chunk(s_w_chunk), .w_data(s_w_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .answer(s_answer), .score(s_score)
`ifdef FINAL_LAYER_MARGIN_EN
        , .margin(s_margin)
`endif
    );

    // Combinational weight ROMs
    always_comb w_data   = rom[w_class][int'(w_chunk)*CW +: CW];
    always_comb s_w_data = s_rom[s_w_class][int'(s_w_chunk)*SCW +: SCW];

    function automatic logic [N-1:0] rand_vec();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[N-1:0];
    endfunction

    // Row agreeing with d in exactly k of the low n bits
    function automatic logic [N-1:0] make_row(input logic [N-1:0] d, input int k, input int n);
        logic [N-1:0] m;
        int rot;
        m = '0;
        rot = $urandom_range(0, n - 1);
        for (int i = 0; i < n - k; i++) m[(i + rot) % n] = 1'b1;
        return d ^ m;
    endfunction

    // Reference: score = agreeing bits, first maximum wins, margin = top minus runner-up
    function automatic void ref_model(input logic [N-1:0] d, output int ans, output int best, output int mg);
        int q[$];
        int s;
        ans = 0;
        best = -1;
        for (int c = 0; c < NC; c++) begin
            s = N - $countones(d ^ rom[c]);
            q.push_back(s);
            if (s > best) begin best = s; ans = c; end
        end
        q.rsort();
        mg = q[0] - q[1];
    endfunction

    // Present one vector, measure cycles to out_valid and record the address walk
    task automatic do_op(input logic [N-1:0] d, output int lat, output int ans, output int sc,
                         output int mg, output bit addr_ok);
        int g;
        g = 0;
        @(negedge clock);
        in_valid = 1'b1;
        data_in  = d;
        while (!in_ready && g < 100) begin @(negedge clock); g++; end
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = -1;
        addr_ok = 1'b1;
        for (int j = 0; j <= 200; j++) begin
            if (j < NC*NCH && (int'(w_class) != j / NCH || int'(w_chunk) != j % NCH)) addr_ok = 1'b0;
            if (out_valid) begin lat = j; break; end
            @(posedge clock); #1;
        end
        ans = int'(answer);
        sc  = int'(score);
`ifdef FINAL_LAYER_MARGIN_EN
        mg  = int'(margin);
`else
        mg  = 0;
`endif
    endtask

    task automatic release_result();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_data_in = '0;
        for (int c = 0; c < 16; c++) rom[c] = '0;
        for (int c = 0; c < 4; c++) s_rom[c] = '0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (answer !== 4'd0 || score !== 8'd0) begin n_errors++; $display("FAIL reset_result: got %0d/%0d want 0/0", answer, score); end
        n_checks++; if (w_class !== 4'd0 || w_chunk !== 2'd0) begin n_errors++; $display("FAIL reset_addr: got %0d/%0d want 0/0", w_class, w_chunk); end
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
        n_checks++; if (s_in_ready !== 1'b1) begin n_errors++; $display("FAIL idle_small_in_ready: got %b want 1", s_in_ready); end
    endtask

    task automatic test_basic();
        int lat, ans, sc, mg;
        bit ok;
        for (int c = 0; c < NC; c++) rom[c] = (c == 3) ? {N{1'b1}} : '0;
        do_op({N{1'b1}}, lat, ans, sc, mg, ok);
        n_checks++; if (lat != 40) begin n_errors++; $display("FAIL basic_latency: got %0d want 40", lat); end
        n_checks++; if (ans != 3 || sc != 196) begin n_errors++; $display("FAIL basic_result: got %0d/%0d want 3/196", ans, sc); end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_rom_addr_walk: got out of order want class-major order"); end
        release_result();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_release: got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_tie();
        int lat, ans, sc, mg;
        bit ok;
        logic [N-1:0] d;
        d = rand_vec();
        for (int c = 0; c < NC; c++) rom[c] = make_row(d, (c == 2 || c == 7) ? 150 : 100, N);
        do_op(d, lat, ans, sc, mg, ok);
        n_checks++; if (ans != 2 || sc != 150) begin n_errors++; $display("FAIL tie_result: got %0d/%0d want 2/150", ans, sc); end
        n_checks++; if (lat != 40) begin n_errors++; $display("FAIL tie_latency: got %0d want 40", lat); end
        release_result();
    endtask

    task automatic test_zero();
        int lat, ans, sc, mg;
        bit ok;
        for (int c = 0; c < NC; c++) rom[c] = {N{1'b1}};
        do_op('0, lat, ans, sc, mg, ok);
        n_checks++; if (ans != 0 || sc != 0) begin n_errors++; $display("FAIL zero_result: got %0d/%0d want 0/0", ans, sc); end
        release_result();
    endtask

    task automatic test_random();
        int lat, ans, sc, mg, e_ans, e_sc, e_mg;
        bit ok;
        logic [N-1:0] d;
        for (int it = 0; it < 8; it++) begin
            d = rand_vec();
            for (int c = 0; c < NC; c++) rom[c] = make_row(d, $urandom_range(60, 180), N);
            if (it % 2 == 0) rom[$urandom_range(0, NC - 1)] = rand_vec();
            ref_model(d, e_ans, e_sc, e_mg);
            do_op(d, lat, ans, sc, mg, ok);
            n_checks++; if (ans != e_ans || sc != e_sc) begin n_errors++; $display("FAIL random_result[%0d]: got %0d/%0d want %0d/%0d", it, ans, sc, e_ans, e_sc); end
`ifdef FINAL_LAYER_MARGIN_EN
            n_checks++; if (mg != e_mg) begin n_errors++; $display("FAIL random_margin[%0d]: got %0d want %0d", it, mg, e_mg); end
`endif
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat, ans, sc, mg, e_ans, e_sc, e_mg;
        bit ok;
        logic [N-1:0] d;
        d = rand_vec();
        for (int c = 0; c < NC; c++) rom[c] = make_row(d, $urandom_range(60, 150), N);
        rom[5] = d;
        ref_model(d, e_ans, e_sc, e_mg);
        do_op(d, lat, ans, sc, mg, ok);
        n_checks++; if (ans != e_ans || sc != e_sc) begin n_errors++; $display("FAIL bp_result: got %0d/%0d want %0d/%0d", ans, sc, e_ans, e_sc); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            in_valid = (k == 1 || k == 2);
            data_in  = ~d;
            @(posedge clock); #1;
            n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_hold_flags[%0d]: got vld=%b rdy=%b want 1/0", k, out_valid, in_ready); end
            n_checks++; if (int'(answer) != e_ans || int'(score) != e_sc) begin n_errors++; $display("FAIL bp_hold_result[%0d]: got %0d/%0d want %0d/%0d", k, answer, score, e_ans, e_sc); end
        end
        in_valid = 1'b0;
        n_checks++; if (u_dut.r_data !== d) begin n_errors++; $display("FAIL bp_data_reg: got %h want %h", u_dut.r_data, d); end
        release_result();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release: got rdy=%b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat, ans, sc, mg, e_ans, e_sc, e_mg;
        bit ok;
        logic [N-1:0] d;
        d = rand_vec();
        for (int c = 0; c < NC; c++) rom[c] = make_row(d, $urandom_range(60, 150), N);
        @(negedge clock);
        in_valid = 1'b1; data_in = d;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_flags: got vld=%b rdy=%b want 0/0", out_valid, in_ready); end
        n_checks++; if (answer !== 4'd0 || score !== 8'd0) begin n_errors++; $display("FAIL midrst_result: got %0d/%0d want 0/0", answer, score); end
        n_checks++; if (w_class !== 4'd0 || w_chunk !== 2'd0) begin n_errors++; $display("FAIL midrst_addr: got %0d/%0d want 0/0", w_class, w_chunk); end
        @(negedge clock); reset = 1'b0;
        d = rand_vec();
        for (int c = 0; c < NC; c++) rom[c] = make_row(d, $urandom_range(60, 180), N);
        ref_model(d, e_ans, e_sc, e_mg);
        do_op(d, lat, ans, sc, mg, ok);
        n_checks++; if (lat != 40) begin n_errors++; $display("FAIL midrst_latency: got %0d want 40", lat); end
        n_checks++; if (ans != e_ans || sc != e_sc) begin n_errors++; $display("FAIL midrst_after: got %0d/%0d want %0d/%0d", ans, sc, e_ans, e_sc); end
        release_result();
    endtask

    task automatic test_param_sweep();
        logic [N-1:0] d;
        int lat, g;
        int sc_tab [3] = '{10, 60, 30};
        d = '0;
        d[SN-1:0] = rand_vec() >> (N - SN);
        for (int c = 0; c < SNC; c++) begin
            logic [N-1:0] r;
            r = make_row(d, sc_tab[c], SN);
            s_rom[c] = r[SN-1:0];
        end
        g = 0;
        @(negedge clock);
        s_in_valid = 1'b1; s_data_in = d[SN-1:0];
        while (!s_in_ready && g < 100) begin @(negedge clock); g++; end
        @(posedge clock); #1;
        s_in_valid = 1'b0;
        lat = -1;
        for (int j = 0; j <= 100; j++) begin
            if (s_out_valid) begin lat = j; break; end
            @(posedge clock); #1;
        end
        n_checks++; if (lat != 12) begin n_errors++; $display("FAIL sweep_latency: got %0d want 12", lat); end
        n_checks++; if (s_answer !== 2'd1 || s_score !== 7'd60) begin n_errors++; $display("FAIL sweep_result: got %0d/%0d want 1/60", s_answer, s_score); end
`ifdef FINAL_LAYER_MARGIN_EN
        n_checks++; if (s_margin !== 7'd30) begin n_errors++; $display("FAIL sweep_margin: got %0d want 30", s_margin); end
`endif
        @(negedge clock); s_out_ready = 1'b1;
        @(posedge clock); #1; s_out_ready = 1'b0;
        n_checks++; if (s_in_ready !== 1'b1) begin n_errors++; $display("FAIL sweep_release: got %b want 1", s_in_ready); end
    endtask

`ifdef FINAL_LAYER_MARGIN_EN
    task automatic test_margin();
        int lat, ans, sc, mg;
        bit ok;
        logic [N-1:0] d;
        int tab [10] = '{140, 150, 90, 80, 80, 80, 80, 80, 80, 80};
        d = rand_vec();
        for (int c = 0; c < NC; c++) rom[c] = make_row(d, tab[c], N);
        do_op(d, lat, ans, sc, mg, ok);
        n_checks++; if (ans != 1 || sc != 150 || mg != 10) begin n_errors++; $display("FAIL margin_result: got %0d/%0d/%0d want 1/150/10", ans, sc, mg); end
        release_result();
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_zero();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_param_sweep();
`ifdef FINAL_LAYER_MARGIN_EN
        test_margin();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
